vga_sync_gen: RTL
=================

# vga_sync_gen

Raster timing generator for the 640x480 @ 60 Hz VGA output, clocked from the 25 MHz pixel clock. It produces the pixel column/row counters (`CounterX`, `CounterY`) consumed by `vga_controller`, the active-low horizontal and vertical sync pulses driven to the connector, and the display-enable, line/frame strobes and frame counter used by game-state logic. All outputs are registered and mutually consistent: every output in a given cycle describes the pixel at the presented (`CounterX`, `CounterY`).

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Derived values:
- H_TOTAL = sum of the four horizontal parameters (800).
- V_TOTAL = sum of the four vertical parameters (525).

Ports:
- `clk`  in  1  25 MHz pixel clock; all logic on its rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  advances the raster when high; when low, all state holds.
- `CounterX`  out  10  current pixel column, 0..H_TOTAL-1.
- `CounterY`  out  10  current line, 0..V_TOTAL-1.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `in_display`  out  1  high when `CounterX` < H_VISIBLE and `CounterY` < V_VISIBLE.
- `line_start`  out  1  one-cycle strobe when `CounterX` == 0.
- `frame_start`  out  1  one-cycle strobe when `CounterX` == 0 and `CounterY` == 0.
- `frame_count`  out  8  frames started since reset, mod 256.

## Operation
- **Reset** (`reset_n` low, takes effect immediately):
  - `CounterX` = H_TOTAL-1 and `CounterY` = V_TOTAL-1, i.e. the last pixel of a frame.
  - `hsync` = 1, `vsync` = 1, `in_display` = 0, `line_start` = 0, `frame_start` = 0.
  - `frame_count` = 8'hFF.
- **Horizontal count**, on each edge with `enable` high:
  - `CounterX` increments.
  - At H_TOTAL-1 it wraps to 0, and `CounterY` increments in the same edge.
  - `CounterY` wraps from V_TOTAL-1 to 0.
- **Frame count**: increments (8-bit, 255 -> 0) on the edge that moves the counters to (0,0). The first frame after reset is therefore frame 0.
- **Sync decode**, computed from the next-state counters and registered so it aligns with the presented counters:
  - `hsync` is low iff H_VISIBLE+H_FRONT <= `CounterX` < H_VISIBLE+H_FRONT+H_SYNC, i.e. columns 656..751.
  - `vsync` is low iff V_VISIBLE+V_FRONT <= `CounterY` < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491.
  - `vsync` is line-based: it changes only when `CounterX` becomes 0.
- **`line_start` / `frame_start`**: high for exactly the one cycle the counters present the matching position. If `enable` drops while they are high, they stay high, because they are state. They are position indicators, not edge counters.
- **`enable` low**: no counter, output or strobe changes. Resuming continues from the held position with no skip.
- **Reset mid-frame**: immediate return to the reset values. The first enabled edge after release presents (0,0) with `frame_start` = 1 and `frame_count` = 0.

## Timing
- Latency from the enabled edge to the new outputs is 0 cycles beyond the register: all outputs update on the same edge.
- No combinational path from inputs to outputs.
- Line period is 800 enabled cycles.
- Frame period is 420,000 enabled cycles (about 16.8 ms at 25 MHz).
- `in_display` is high for 640 consecutive cycles per visible line, and for 0 cycles on lines 480..524.

## Test plan
1. **Reset release**: hold `reset_n` low 5 cycles, release with `enable` = 1.
   - During reset: outputs (799, 524), `hsync` = `vsync` = 1, `in_display` = 0, `frame_count` = 255.
   - After the first edge: (0,0), `frame_start` = 1, `line_start` = 1, `in_display` = 1, `frame_count` = 0.
2. **Line timing**: run one line.
   - `in_display` high for `CounterX` 0..639.
   - `hsync` low for exactly 96 cycles starting at `CounterX` = 656.
   - At 799 -> 0, `CounterY` increments and `line_start` pulses once.
3. **Frame timing**: run 420,000 cycles.
   - `vsync` low exactly for `CounterY` 490..491, which is 1600 cycles.
   - The wrap returns to (0,0) with `frame_start` = 1 and `frame_count` = 1.
4. **Enable stall**: drop `enable` for 37 cycles at (798, 9).
   - All outputs stay frozen.
   - After re-enable: (799, 9), then (0, 10) with `line_start` = 1.
5. **Frame counter wrap**: force through 256 frames.
   - `frame_count` goes 255 -> 0 at frame start.
   - No glitch on the counters.
6. **Async reset mid-frame**: assert `reset_n` low between clock edges at (300, 200).
   - Outputs go to reset values before the next edge.
   - Release gives (0,0) on the first enabled edge.

Source files
------------

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : Raster timing generator for 640x480 @ 60 Hz VGA (25 MHz pixel
//            clock). Produces pixel column/row counters, active-low sync
//            pulses, display enable, line/frame strobes and a frame counter.
//            Every output is registered and describes the pixel at the
//            presented (CounterX, CounterY).
// Ports    :
//   clk          in   pixel clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   enable       in   advance the raster when high, hold everything when low
//   CounterX     out  current pixel column, 0..H_TOTAL-1
//   CounterY     out  current line, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   in_display   out  pixel lies inside the visible area
//   line_start   out  high while CounterX == 0
//   frame_start  out  high while CounterX == 0 and CounterY == 0
//   frame_count  out  frames started since reset, mod 256
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [9:0] CounterX,
  output logic [9:0] CounterY,
  output logic       hsync,
  output logic       vsync,
  output logic       in_display,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] C_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] C_HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] C_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] C_VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] C_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       w_x_wrap;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_hsync_next;
  logic       w_vsync_next;
  logic       w_de_next;
  logic       w_line_next;
  logic       w_frame_next;

  // All decodes look at the next-state counters so that the registered
  // flags line up with the counter values presented in the same cycle.
  always_comb begin
    w_x_wrap = (CounterX == C_H_LAST);
    w_x_next = w_x_wrap ? 10'd0 : CounterX + 10'd1;
    w_y_next = CounterY;
    if (w_x_wrap) begin
      w_y_next = (CounterY == C_V_LAST) ? 10'd0 : CounterY + 10'd1;
    end
    w_hsync_next = !((w_x_next >= C_HS_START) && (w_x_next < C_HS_END));
    // Y only moves when X wraps, so vsync is inherently line-aligned.
    w_vsync_next = !((w_y_next >= C_VS_START) && (w_y_next < C_VS_END));
    w_de_next    = (w_x_next < C_H_VIS) && (w_y_next < C_V_VIS);
    w_line_next  = (w_x_next == 10'd0);
    w_frame_next = (w_x_next == 10'd0) && (w_y_next == 10'd0);
  end

  // Reset parks the raster on the last pixel of a frame with frame_count at
  // 8'hFF, so the first enabled edge lands on (0,0) as frame 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      CounterX    <= C_H_LAST;
      CounterY    <= C_V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      in_display  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'hFF;
    end else if (enable) begin
      CounterX    <= w_x_next;
      CounterY    <= w_y_next;
      hsync       <= w_hsync_next;
      vsync       <= w_vsync_next;
      in_display  <= w_de_next;
      line_start  <= w_line_next;
      frame_start <= w_frame_next;
      if (w_frame_next) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
